// File: rtl/cnnip_arb_pkg.sv
// Shared types for the block-memory port arbiter: FSM states and
// the width of the outstanding-read counter.
package cnnip_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // Three bits covers MAX_OUTSTANDING up to 7.
  localparam int OUT_CNT_W = 3;

endpackage

// File: rtl/cnnip_mem_if.sv
// Single block-memory port: the master drives the access, the memory
// answers with read data qualified by valid.
interface cnnip_mem_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  en;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  valid;

  modport master (output en, output we, output addr, output din,
                  input dout, input valid);
  modport slave  (input en, input we, input addr, input din,
                  output dout, output valid);
endinterface

// File: rtl/cnnip_rr_pick.sv
// Combinational round-robin picker: the search starts one past the last
// owner and wraps, so the last owner is considered last.
module cnnip_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_i) + k) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/cnnip_mem_arbiter.sv
// Round-robin owner arbitration for one block-memory port. The owner's
// accesses pass straight through; read returns are steered back to it.
module cnnip_mem_arbiter
  import cnnip_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_BURST       = 16
) (
  input  logic                          clk_a,
  input  logic                          arstz_aq,
  input  logic [NUM_REQ-1:0]            req_en,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [NUM_REQ-1:0]            req_valid,
  output logic [DATA_WIDTH-1:0]         req_dout,
  cnnip_mem_if.master                   mem_if,
  output logic                          err_underflow
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_owner_q, last_owner_d;
  logic [OUT_CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [BURST_W-1:0]     burst_q, burst_d;
  logic                   err_q, err_d;

  logic [NUM_REQ-1:0]     pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_REQ-1:0]     owner_oh;
  logic                   own_en, own_we;
  logic [ADDR_WIDTH-1:0]  own_addr;
  logic [DATA_WIDTH-1:0]  own_din;
  logic                   others_req, at_burst, at_max_out, burst_stall;
  logic                   own_gnt, accept, rd_accept, ret_ok;

  cnnip_rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .req_i  (req_en),
    .last_i (last_owner_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign own_en   = req_en[owner_q];
  assign own_we   = req_we[owner_q];
  assign own_addr = req_addr[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
  assign own_din  = req_din[owner_q*DATA_WIDTH +: DATA_WIDTH];

  // Stall terms come only from registered counters, so the grant drops in
  // the very cycle a limit is reached.
  assign others_req  = |(req_en & ~owner_oh);
  assign at_burst    = (burst_q == BURST_W'(MAX_BURST));
  assign at_max_out  = (out_cnt_q == OUT_CNT_W'(MAX_OUTSTANDING));
  assign burst_stall = at_burst & others_req;
  assign own_gnt     = (state_q == OWN) & ~at_max_out & ~burst_stall;
  assign accept      = own_gnt & own_en;
  assign rd_accept   = accept & ~own_we;
  assign ret_ok      = mem_if.valid & (out_cnt_q != '0);

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      out_cnt_q    <= '0;
      burst_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      out_cnt_q    <= out_cnt_d;
      burst_q      <= burst_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    out_cnt_d    = out_cnt_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (|pick_gnt) begin
          state_d = OWN;
          owner_d = pick_idx;
          burst_d = '0;
        end
      end
      OWN: begin
        if (accept && !at_burst) begin
          burst_d = burst_q + BURST_W'(1);
        end
        if (!own_en || burst_stall) begin
          state_d      = (out_cnt_q != '0) ? DRAIN : IDLE;
          last_owner_d = owner_q;
        end
      end
      DRAIN: begin
        if (out_cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A return with nothing in flight is dropped and latched as an error.
    case ({rd_accept, ret_ok})
      2'b10:   out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
      2'b01:   out_cnt_d = out_cnt_q - OUT_CNT_W'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
    if (mem_if.valid && (out_cnt_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    req_gnt       = own_gnt ? owner_oh : '0;
    mem_if.en     = accept;
    mem_if.we     = own_we & own_gnt;
    mem_if.addr   = own_gnt ? own_addr : '0;
    mem_if.din    = own_gnt ? own_din : '0;
    req_valid     = ret_ok ? owner_oh : '0;
    req_dout      = mem_if.dout;
    err_underflow = err_q;
  end

endmodule
